// File: rtl/mxv_result_collector.sv
// Result collector: captures flagged MxV result words into a first-word-fall-through
// FIFO and streams them downstream, tagging the last word. Optional: MXV_COLLECT_OVF_DETECT_EN.
module mxv_result_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [7:0]            matrix_size_real_i,
  input  logic                  result_push_i,
  input  logic [DATA_WIDTH-1:0] result_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o
);

  localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W      = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        size_q, size_d;
  logic [CNT_W-1:0]        cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]        sent_cnt_q, sent_cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic start_acc;
  logic push_take;
  logic push_acc;
  logic pop;

  // Handshake decode: a push counts toward the operation even when it is dropped.
  always_comb begin
    start_acc = (state_q == S_IDLE) && start_i && (matrix_size_real_i != '0);
    pop       = !empty_q && out_ready_i;
    push_take = (state_q == S_COLLECT) && result_push_i && (cap_cnt_q < size_q);
    push_acc  = push_take && (!full_q || pop);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    cap_cnt_d  = cap_cnt_q;
    sent_cnt_d = sent_cnt_q + CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = OCC_W'(occ_q + OCC_W'(push_acc) - OCC_W'(pop));

    if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          size_d     = matrix_size_real_i;
          cap_cnt_d  = '0;
          sent_cnt_d = '0;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (push_take) cap_cnt_d = cap_cnt_q + CNT_W'(1);
        if (cap_cnt_q == size_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // An empty FIFO here means dropped words will never arrive.
        if ((sent_cnt_q == size_q) || empty_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    full_d  = (occ_d == OCC_W'(DEPTH));
    empty_d = (occ_d == '0);
    last_d  = !empty_d && (sent_cnt_d == CNT_W'(size_d - CNT_W'(1)));
    busy_d  = (state_d == S_COLLECT) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      cap_cnt_q  <= '0;
      sent_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      cap_cnt_q  <= cap_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Storage is cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_acc) begin
      mem_q[wr_ptr_q] <= result_data_i;
    end
  end

`ifdef MXV_COLLECT_OVF_DETECT_EN
  logic overflow_q, overflow_d;
  logic push_drop;
  logic idle_push;

  // Sticky until the next accepted start.
  always_comb begin
    push_drop  = push_take && full_q && !pop;
    idle_push  = (state_q == S_IDLE) && result_push_i;
    overflow_d = overflow_q;
    if (start_acc)                   overflow_d = 1'b0;
    else if (push_drop || idle_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) overflow_q <= 1'b0;
    else           overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign out_valid_o = !empty_q;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign out_last_o  = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: doc/mxv_result_collector.md
Name: mxv_result_collector

Overview:
- Receiving end of the matrix-vector result stream: captures each result word the operation counter flags with result_push.
- Buffers captured words in a small FIFO and sends them downstream on a valid/ready interface, tagging the final word of the operation.
- Sits between the MxV datapath/op counter and the output transmitter; one operation = matrix_size_real results.

Parameters:
- DATA_WIDTH, 16, width of one result word.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ADDR_WIDTH, CeilLog2(DEPTH), FIFO pointer width, derived.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle pulse; arms collection of a new operation.
- matrix_size_real  in  8  results expected this operation; sampled on the start cycle.
- result_push  in  1  result_data is valid this cycle.
- result_data  in  DATA_WIDTH  result word.
- out_valid  out  1  out_data holds a buffered word.
- out_data  out  DATA_WIDTH  head-of-FIFO word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_last  out  1  the current out word is the final word of the operation.
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse; all expected words transferred.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- overflow  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset values: out_valid=0, out_last=0, busy=0, done=0, full=0, empty=1, overflow=0, out_data=0. All counters and pointers are 0. State is IDLE. Reset mid-operation discards the buffered data.
- The FIFO read is first-word-fall-through. out_data=mem[rd_ptr] and out_valid=!empty. A transfer occurs when out_valid&&out_ready.
- Counters are 8 bits wide: size_q (latched size), cap_cnt (words captured), sent_cnt (words transferred). Occupancy is ADDR_WIDTH+1 bits.
- IDLE:
  - busy=0. result_push is ignored.
  - start with matrix_size_real!=0: latch size_q, clear cap_cnt/sent_cnt/overflow, go to COLLECT.
  - start with size 0 is ignored.
- COLLECT:
  - A push is accepted when result_push=1, cap_cnt<size_q, and the FIFO is not full. It is written at wr_ptr and cap_cnt is incremented.
  - Pushes after cap_cnt==size_q are ignored silently.
  - A push while full is dropped (see overflow). cap_cnt still increments, so the operation terminates.
  - Draining proceeds concurrently.
  - Go to DRAIN on the cycle after cap_cnt reaches size_q.
- DRAIN: no pushes are accepted. Transfers continue until sent_cnt==size_q, then go to DONE.
  - If a dropped word leaves fewer stored words than size_q, go to DONE when the FIFO is empty.
- DONE: done=1 for exactly one cycle, then IDLE. start in this cycle is ignored.
- start in COLLECT, DRAIN or DONE is ignored.
- Simultaneous push and pop while full: both proceed, occupancy is unchanged, and the push is not dropped.
- Simultaneous push and pop while empty: the push lands. out_valid rises the next cycle, so the fall-through latency is 1 cycle.
- out_last = out_valid && (sent_cnt == size_q-1).
- Pointers wrap modulo DEPTH. full and empty are derived from occupancy, registered with pointers.

Optional Feature:
- Macro: MXV_COLLECT_OVF_DETECT_EN.
- Defined:
  - A push dropped because the FIFO is full sets overflow=1.
  - overflow stays 1 until reset or the next accepted start.
  - A push in IDLE also sets overflow.
- Not defined:
  - overflow is tied to 0.
  - Dropped pushes are discarded silently.
  - Detection logic is not synthesized.

Test Plan:
- Reset, then start with size=4; push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1. Expected: out words appear 1 cycle after each push; out_last only with 0x44; done pulses once; busy falls after done.
- size=8, DEPTH=8, out_ready=0 while pushing 8 words. Expected: full=1 after the 8th push; raising out_ready drains 8 words in order; empty=1 at the end; out_last on the 8th word.
- size=10, DEPTH=8, out_ready=0 for 10 pushes. Expected: 2 pushes dropped. With the macro, overflow=1. Without it, overflow=0. Drain returns the first 8 words, then done.
- FIFO full, then push and pop in the same cycle. Expected: occupancy stays 8, no overflow, the new word is last out.
- start during COLLECT with size=2. Expected: ignored; the operation completes with the original size. start with size=0 in IDLE: busy stays 0.
- Assert reset mid-DRAIN with 3 words buffered. Expected: all outputs return to reset values immediately; a following operation with size=1 completes normally.
